// File: rtl/column_prefetch.sv
// Column prefetcher: streams one texture column from ROM into a back line buffer
// and exposes it to the strip driver only after a refresh wrap, brightness-scaled.
module column_prefetch #(
    parameter int LED_COUNT  = 52,
    parameter int TEX_WIDTH  = 64,
    parameter int NUM_FRAMES = 30,
    parameter int ADDR_W     = 17,
    parameter int PX_W       = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        col,
    input  logic [7:0]        frame_idx,
    input  logic [1:0]        brightness,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    input  logic [PX_W-1:0]   rd_idx,
    output logic [23:0]       rd_pixel,
    output logic              fill_busy,
    output logic              swap_pulse
);
    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'(TEX_WIDTH * LED_COUNT);
    localparam logic [ADDR_W-1:0] ROW_STRIDE   = ADDR_W'(TEX_WIDTH);
    localparam logic [PX_W-1:0]   LAST_PX      = PX_W'(LED_COUNT - 1);

    state_t state_reg, state_next;

    logic [5:0]      last_col_reg, req_col_reg;
    logic [7:0]      last_frame_reg, req_frame_reg;
    logic [PX_W-1:0] px_cnt_reg, wr_idx_reg, last_rd_reg;
    logic            wr_en_reg, force_fill_reg, pending_swap_reg;
    logic            front_sel_reg, front_valid_reg;

    logic            request, wrap, swap_now;
    logic            start_fill, issue_addr, finish_fill;
    logic [7:0]      frame_eff;
    logic [PX_W-1:0] rd_safe;
    logic [23:0]     rd_word, rd_scaled;

    // Both line buffers share one array; the select bit picks front vs back.
    logic [23:0] line_mem [0:1][0:LED_COUNT-1];

    assign frame_eff = (32'(frame_idx) >= NUM_FRAMES) ? 8'd0 : frame_idx;
    assign request   = force_fill_reg || (col != last_col_reg) || (frame_idx != last_frame_reg);
    assign wrap      = (last_rd_reg == LAST_PX) && (rd_idx == '0);
    assign swap_now  = wrap && pending_swap_reg;
    assign rd_safe   = (32'(rd_idx) < LED_COUNT) ? rd_idx : '0;
    assign rd_word   = line_mem[front_sel_reg][rd_safe];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_scale
            assign rd_scaled[gi*8 +: 8] = rd_word[gi*8 +: 8] >> brightness;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Any new request preempts an in-flight fill; only an uninterrupted fill drains.
    always_comb begin
        state_next  = state_reg;
        start_fill  = 1'b0;
        issue_addr  = 1'b0;
        finish_fill = 1'b0;
        case (state_reg)
            IDLE: begin
                if (request) begin
                    start_fill = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (request) begin
                    start_fill = 1'b1;
                end else begin
                    issue_addr = 1'b1;
                    if (px_cnt_reg == LAST_PX) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (request) begin
                    start_fill = 1'b1;
                    state_next = FILL;
                end else begin
                    finish_fill = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rom_addr         <= '0;
            rd_pixel         <= '0;
            fill_busy        <= 1'b0;
            swap_pulse       <= 1'b0;
            front_sel_reg    <= 1'b0;
            front_valid_reg  <= 1'b0;
            pending_swap_reg <= 1'b0;
            force_fill_reg   <= 1'b1;
            last_col_reg     <= '0;
            last_frame_reg   <= '0;
            last_rd_reg      <= '0;
            req_col_reg      <= '0;
            req_frame_reg    <= '0;
            px_cnt_reg       <= '0;
            wr_idx_reg       <= '0;
            wr_en_reg        <= 1'b0;
        end else begin
            last_col_reg   <= col;
            last_frame_reg <= frame_idx;
            last_rd_reg    <= rd_idx;
            wr_en_reg      <= issue_addr;
            swap_pulse     <= swap_now;
            rd_pixel       <= (front_valid_reg && (32'(rd_idx) < LED_COUNT)) ? rd_scaled : 24'd0;

            if (start_fill) begin
                req_col_reg      <= col;
                req_frame_reg    <= frame_eff;
                px_cnt_reg       <= '0;
                force_fill_reg   <= 1'b0;
                pending_swap_reg <= 1'b0;
                fill_busy        <= 1'b1;
            end
            if (issue_addr) begin
                rom_addr   <= ADDR_W'(req_frame_reg) * FRAME_STRIDE
                            + ADDR_W'(px_cnt_reg) * ROW_STRIDE
                            + ADDR_W'(req_col_reg);
                px_cnt_reg <= px_cnt_reg + 1'b1;
                wr_idx_reg <= px_cnt_reg;
            end
            if (finish_fill) begin
                pending_swap_reg <= 1'b1;
                fill_busy        <= 1'b0;
            end
            if (swap_now) begin
                front_sel_reg    <= !front_sel_reg;
                front_valid_reg  <= 1'b1;
                pending_swap_reg <= 1'b0;
            end
        end
    end

    // ROM data arrives one cycle after its address, hence the delayed write index.
    always_ff @(posedge clk) begin
        if (wr_en_reg) begin
            line_mem[!front_sel_reg][wr_idx_reg] <= rom_data;
        end
    end
endmodule

// File: tb/tb_column_prefetch.sv
// Bench for column_prefetch: a column-level behavioural model checked every
// cycle, directed literal expectations, and a randomized stimulus phase.
`timescale 1ns/1ps
module tb_column_prefetch;
    localparam int LEDS   = 52;
    localparam int TEXW   = 64;
    localparam int FRAMES = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  col = 6'd5;
    logic [7:0]  frame_idx = 8'd0;
    logic [1:0]  brightness = 2'd0;
    logic [16:0] rom_addr;
    logic [23:0] rom_data;
    logic [5:0]  rd_idx = 6'd0;
    logic [23:0] rd_pixel;
    logic        fill_busy;
    logic        swap_pulse;
    int          rom_mode = 0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    column_prefetch dut (
        .clk(clk), .reset(reset), .col(col), .frame_idx(frame_idx),
        .brightness(brightness), .rom_addr(rom_addr), .rom_data(rom_data),
        .rd_idx(rd_idx), .rd_pixel(rd_pixel), .fill_busy(fill_busy),
        .swap_pulse(swap_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] rom_fn(input int mode, input logic [16:0] a);
        int unsigned h;
        h = 32'(a) * 32'd40503 + 32'h1234;
        if (mode == 0) return {7'd0, a};
        if (mode == 1) return 24'hFF8040;
        return h[23:0];
    endfunction

    assign rom_data = rom_fn(rom_mode, rom_addr);

    function automatic logic [16:0] col_addr(input int frame, input int px, input int c);
        int a;
        a = frame * TEXW * LEDS + px * TEXW + c;
        return a[16:0];
    endfunction

    function automatic logic [23:0] scale(input logic [23:0] p, input logic [1:0] b);
        int d, g, r, bl;
        d  = 2 ** int'(b);
        g  = int'(p[23:16]) / d;
        r  = int'(p[15:8]) / d;
        bl = int'(p[7:0]) / d;
        return {g[7:0], r[7:0], bl[7:0]};
    endfunction

    task automatic check_eq(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // Behavioural model: whole-column snapshots, a fill age counter and a pending flag.
    logic [16:0] e_rom_addr;
    logic [23:0] e_rd_pixel;
    bit          e_busy, e_swap;
    int          m_last_col, m_last_frame, m_last_rd, m_age, m_req_col, m_req_frame;
    bit          m_force, m_busy, m_pending, m_front_valid;
    bit          m_ready = 1'b0;
    logic [23:0] m_front [LEDS];
    logic [23:0] m_back  [LEDS];

    task automatic model_step();
        bit req, wrap;
        int fr;
        if (!reset) begin
            e_rom_addr = '0; e_rd_pixel = '0; e_busy = 0; e_swap = 0;
            m_force = 1; m_busy = 0; m_age = 0; m_pending = 0; m_front_valid = 0;
            m_last_col = 0; m_last_frame = 0; m_last_rd = 0;
        end else begin
            req  = m_force || (int'(col) != m_last_col) || (int'(frame_idx) != m_last_frame);
            wrap = (m_last_rd == LEDS - 1) && (int'(rd_idx) == 0);
            e_rd_pixel = (m_front_valid && int'(rd_idx) < LEDS) ? scale(m_front[rd_idx], brightness) : 24'd0;
            e_swap = wrap && m_pending;
            if (e_swap) begin
                m_front = m_back;
                m_front_valid = 1;
                m_pending = 0;
            end
            if (req) begin
                fr = int'(frame_idx);
                m_busy = 1; m_age = 0; m_req_col = int'(col);
                m_req_frame = (fr >= FRAMES) ? 0 : fr;
                m_force = 0; m_pending = 0; e_busy = 1;
            end else if (m_busy) begin
                if (m_age < LEDS) begin
                    e_rom_addr = col_addr(m_req_frame, m_age, m_req_col);
                    m_age++;
                end else begin
                    m_busy = 0; e_busy = 0; m_pending = 1;
                    for (int px = 0; px < LEDS; px++)
                        m_back[px] = rom_fn(rom_mode, col_addr(m_req_frame, px, m_req_col));
                end
            end
            m_last_col = int'(col); m_last_frame = int'(frame_idx); m_last_rd = int'(rd_idx);
        end
        m_ready = 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        cyc++;
        if (m_ready) begin
            check_eq("model_rom_addr", int'(rom_addr), int'(e_rom_addr));
            check_eq("model_rd_pixel", int'(rd_pixel), int'(e_rd_pixel));
            check_eq("model_fill_busy", int'(fill_busy), int'(e_busy));
            check_eq("model_swap_pulse", int'(swap_pulse), int'(e_swap));
        end
    end

    int swaps = 0;

    task automatic step(input bit spin);
        if (spin) rd_idx = (rd_idx >= 6'(LEDS - 1)) ? 6'd0 : rd_idx + 6'd1;
        @(negedge clk);
        if (swap_pulse) swaps++;
    endtask

    task automatic wait_busy(input bit level, input int limit, input bit spin, input string what);
        int n = 0;
        while (fill_busy !== level && n < limit) begin
            step(spin);
            n++;
        end
        check_eq(what, int'(fill_busy), int'(level));
    endtask

    task automatic do_wrap();
        rd_idx = 6'(LEDS - 1);
        step(0);
        rd_idx = 6'd0;
        step(0);
    endtask

    int busy_cnt;
    int addrs[$];
    int bad_seq;
    int max_addr;

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset_rom_addr", int'(rom_addr), 0);
        check_eq("reset_rd_pixel", int'(rd_pixel), 0);
        check_eq("reset_fill_busy", int'(fill_busy), 0);
        check_eq("reset_swap_pulse", int'(swap_pulse), 0);
        $display("txn reset: outputs sampled during reset");

        // First fill: col 5, frame 0, ROM returns its address.
        reset = 1'b1;
        wait_busy(1, 5, 0, "fill1_start");
        busy_cnt = 0;
        while (fill_busy && busy_cnt < 100) begin
            busy_cnt++;
            if (busy_cnt >= 2) addrs.push_back(int'(rom_addr));
            step(0);
        end
        check_eq("fill1_busy_cycles", busy_cnt, 53);
        check_eq("fill1_addr_count", addrs.size(), 52);
        bad_seq = 0;
        foreach (addrs[i]) if (addrs[i] != 5 + 64 * i) bad_seq++;
        check_eq("fill1_addr_seq_errors", bad_seq, 0);
        if (addrs.size() == 52) check_eq("fill1_last_addr", addrs[51], 3269);
        $display("txn fill col=5 frame=0: %0d busy cycles, %0d addresses", busy_cnt, addrs.size());

        rd_idx = 6'd3;
        step(0);
        check_eq("pre_swap_read", int'(rd_pixel), 0);
        swaps = 0;
        do_wrap();
        check_eq("swap_on_wrap", int'(swap_pulse), 1);
        rd_idx = 6'd3;
        step(0);
        check_eq("swap_one_cycle", int'(swap_pulse), 0);
        check_eq("px3_after_swap", int'(rd_pixel), 197);
        rd_idx = 6'd60;
        step(0);
        check_eq("rd_idx_out_of_range", int'(rd_pixel), 0);
        $display("txn wrap: swap seen, px3=%0d", rd_pixel);

        // Far corner of the ROM.
        frame_idx = 8'd29; col = 6'd63;
        wait_busy(1, 5, 0, "corner_start");
        max_addr = 0;
        for (int n = 0; n < 100 && fill_busy; n++) begin
            if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
            step(0);
        end
        check_eq("corner_max_addr", max_addr, 99839);
        wait_busy(0, 5, 0, "corner_done");
        $display("txn fill col=63 frame=29: max addr %0d", max_addr);

        // Out-of-range frame maps to frame 0.
        frame_idx = 8'd200; col = 6'd1;
        wait_busy(1, 5, 0, "clamp_start");
        step(0);
        check_eq("clamp_first_addr", int'(rom_addr), 1);
        wait_busy(0, 100, 0, "clamp_done");
        $display("txn fill col=1 frame=200: first addr %0d", rom_addr);

        // Brightness scaling on a constant ROM word.
        rom_mode = 1; frame_idx = 8'd0; col = 6'd20;
        wait_busy(1, 5, 0, "bright_start");
        wait_busy(0, 100, 0, "bright_done");
        do_wrap();
        check_eq("bright_swap", int'(swap_pulse), 1);
        brightness = 2'd2; rd_idx = 6'd60;
        step(0);
        check_eq("bright_oor", int'(rd_pixel), 0);
        rd_idx = 6'd7;
        step(0);
        check_eq("bright_shift2", int'(rd_pixel), 24'h3F2010);
        brightness = 2'd3;
        step(0);
        check_eq("bright_shift3", int'(rd_pixel), 24'h1F1008);
        $display("txn brightness: px7=%h", rd_pixel);

        // Abort mid-fill and restart with a new column.
        rom_mode = 2; brightness = 2'd0; frame_idx = 8'd2; col = 6'd10;
        wait_busy(1, 5, 0, "abort_start");
        swaps = 0;
        repeat (20) step(1);
        col = 6'd11;
        step(0);
        step(0);
        check_eq("abort_restart_addr", int'(rom_addr), 6667);
        check_eq("abort_still_busy", int'(fill_busy), 1);
        wait_busy(0, 200, 1, "abort_refill_done");
        check_eq("abort_no_early_swap", swaps, 0);
        repeat (60) step(1);
        check_eq("abort_swap_after_refill", swaps, 1);
        $display("txn abort col 10->11: swaps after refill %0d", swaps);

        // Completed fill whose pending swap gets cancelled by a column change.
        rd_idx = 6'd10; col = 6'd12;
        wait_busy(1, 5, 0, "cancel_start");
        wait_busy(0, 100, 0, "cancel_fill_done");
        col = 6'd13;
        rd_idx = 6'd51;
        step(0);
        rd_idx = 6'd0;
        step(0);
        check_eq("cancel_no_swap", int'(swap_pulse), 0);
        rd_idx = 6'd5;
        step(0);
        check_eq("cancel_front_unchanged", int'(rd_pixel), int'(rom_fn(2, col_addr(2, 5, 11))));
        wait_busy(0, 100, 0, "cancel_refill_done");
        do_wrap();
        check_eq("cancel_swap_after_refill", int'(swap_pulse), 1);
        rd_idx = 6'd5;
        step(0);
        check_eq("cancel_front_new", int'(rd_pixel), int'(rom_fn(2, col_addr(2, 5, 13))));
        $display("txn cancel pending col 12->13: px5=%h", rd_pixel);

        // Reset in the middle of a fill.
        col = 6'd30;
        wait_busy(1, 5, 0, "midreset_start");
        repeat (10) step(0);
        reset = 1'b0;
        step(0);
        check_eq("midreset_rom_addr", int'(rom_addr), 0);
        check_eq("midreset_rd_pixel", int'(rd_pixel), 0);
        check_eq("midreset_fill_busy", int'(fill_busy), 0);
        check_eq("midreset_swap_pulse", int'(swap_pulse), 0);
        reset = 1'b1;
        wait_busy(1, 5, 0, "midreset_refill_start");
        wait_busy(0, 100, 0, "midreset_refill_done");
        $display("txn reset mid-fill: outputs cleared");

        // Randomized traffic; the model checks every cycle.
        swaps = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) == 0) col = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 299) == 0) frame_idx = 8'($urandom_range(0, 40));
            if ($urandom_range(0, 15) == 0) brightness = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 1999) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 99) == 0) begin
                rd_idx = 6'($urandom_range(0, 63));
                step(0);
            end else begin
                step(1);
            end
        end
        reset = 1'b1;
        $display("txn random: 4000 cycles, %0d swaps", swaps);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
